// File: rtl/mpe_wb_pkg.sv
// mpe_wb_pkg: shared types and sizes for the matrix PE result writeback.
// Line geometry, FSM states and the lane element type.
package mpe_wb_pkg;

  localparam int LANES  = 16;
  localparam int LINE_W = LANES * 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  typedef logic [31:0] lane_t;

endpackage

// File: rtl/mpe_wb_fifo.sv
// mpe_wb_fifo: synchronous show-ahead line FIFO for the writeback stage.
// Storage is registered; dout presents the head entry (zero when empty).
module mpe_wb_fifo #(
  parameter int WIDTH = 512,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [AW:0]      r_cnt;
  logic             w_wr;
  logic             w_rd;

  assign full  = (r_cnt == (AW+1)'(DEPTH));
  assign empty = (r_cnt == '0);
  assign w_rd  = pop && !empty;
  // a pop on the same edge frees the slot, so a full FIFO may still accept
  assign w_wr  = push && (!full || w_rd);
  assign dout  = empty ? '0 : r_mem[r_rp];

  // line storage write
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wp] <= din;
    end
  end

  // pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr) begin
        r_wp <= r_wp + 1'b1;
      end
      if (w_rd) begin
        r_rp <= r_rp + 1'b1;
      end
      unique case ({w_wr, w_rd})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/mpe_result_wb.sv
// mpe_result_wb: packs PE results into lines, queues and streams them out.
// Build option MPE_WB_RELU_EN clamps negative results to zero before packing.
module mpe_result_wb
  import mpe_wb_pkg::*;
#(
  parameter int LANES      = mpe_wb_pkg::LANES,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 16,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_start,
  input  logic [ADDR_W-1:0]     cfg_base_addr,
  input  logic [CNT_W-1:0]      cfg_num_res,
  input  logic [31:0]           pe_result,
  input  logic                  pe_vld,
  output logic [LANES*32-1:0]   wb_data,
  output logic [ADDR_W-1:0]     wb_addr,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);

  localparam int LW = LANES * 32;
  localparam int PW = $clog2(LANES);

  state_t            r_state;
  state_t            w_state_nxt;
  lane_t             r_lanes [LANES];
  logic [PW-1:0]     r_ptr;
  logic [CNT_W-1:0]  r_rem;
  logic [ADDR_W-1:0] r_addr;
  logic              r_ovf;

  lane_t             w_val;
  logic [LW-1:0]     w_line;
  logic              w_start;
  logic              w_cap;
  logic              w_last;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;

`ifdef MPE_WB_RELU_EN
  assign w_val = pe_result[31] ? '0 : pe_result;
`else
  assign w_val = pe_result;
`endif

  assign w_start = cfg_start && (r_state == IDLE);
  assign w_cap   = pe_vld && (r_state == RUN);
  assign w_last  = (r_rem == CNT_W'(1));
  assign w_push  = w_cap && ((r_ptr == PW'(LANES - 1)) || w_last);
  assign w_pop   = wb_valid && wb_ready;

  assign wb_valid = !w_empty;
  assign wb_addr  = r_addr;
  assign busy     = (r_state != IDLE);
  assign overflow = r_ovf;

  // outgoing line: stored lanes below ptr, current result at ptr, zeros above
  always_comb begin
    w_line = '0;
    for (int i = 0; i < LANES; i++) begin
      if (i < int'(r_ptr)) begin
        w_line[32*i +: 32] = r_lanes[i];
      end else if (i == int'(r_ptr)) begin
        w_line[32*i +: 32] = w_val;
      end
    end
  end

  // job FSM next state and done pulse
  always_comb begin
    w_state_nxt = r_state;
    done        = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_start) begin
          w_state_nxt = (cfg_num_res == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (w_cap && w_last) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (w_empty) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
        done        = 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // packer, result counter, line address and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr  <= '0;
      r_rem  <= '0;
      r_addr <= '0;
      r_ovf  <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        r_lanes[i] <= '0;
      end
    end else begin
      if (w_start) begin
        r_ptr  <= '0;
        r_rem  <= cfg_num_res;
        r_addr <= cfg_base_addr;
        r_ovf  <= 1'b0;
      end
      if (w_cap) begin
        r_lanes[r_ptr] <= w_val;
        r_rem          <= r_rem - 1'b1;
        r_ptr          <= w_push ? '0 : r_ptr + 1'b1;
      end
      if (w_pop) begin
        r_addr <= r_addr + 1'b1;
      end
      if (w_push && w_full && !w_pop) begin
        r_ovf <= 1'b1;
      end
    end
  end

  mpe_wb_fifo #(
    .WIDTH (LW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .din   (w_line),
    .pop   (w_pop),
    .dout  (wb_data),
    .full  (w_full),
    .empty (w_empty)
  );

endmodule

// File: tb/tb_mpe_result_wb.sv
// tb_mpe_result_wb: directed bench for the PE result writeback stage.
// Transfers are logged by a monitor and compared against bench-built lines.
module tb_mpe_result_wb;

  logic         clk = 1'b0;
  logic         rst;
  logic         cfg_start;
  logic [15:0]  cfg_base_addr;
  logic [15:0]  cfg_num_res;
  logic [31:0]  pe_result;
  logic         pe_vld;
  logic [511:0] wb_data;
  logic [15:0]  wb_addr;
  logic         wb_valid;
  logic         wb_ready;
  logic         busy;
  logic         done;
  logic         overflow;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int stall_err = 0;

  logic [511:0] q_data [$];
  logic [15:0]  q_addr [$];
  logic         prev_stall = 1'b0;
  logic [511:0] prev_d;
  logic [15:0]  prev_a;

  logic [31:0]  vals [1000];

  mpe_result_wb dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_start     (cfg_start),
    .cfg_base_addr (cfg_base_addr),
    .cfg_num_res   (cfg_num_res),
    .pe_result     (pe_result),
    .pe_vld        (pe_vld),
    .wb_data       (wb_data),
    .wb_addr       (wb_addr),
    .wb_valid      (wb_valid),
    .wb_ready      (wb_ready),
    .busy          (busy),
    .done          (done),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (wb_data !== prev_d || wb_addr !== prev_a))
        stall_err++;
      if (wb_valid && wb_ready) begin
        q_data.push_back(wb_data);
        q_addr.push_back(wb_addr);
      end
      prev_stall = wb_valid && !wb_ready;
      prev_d = wb_data;
      prev_a = wb_addr;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] got,
                     input logic [511:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] relu(input logic [31:0] v);
`ifdef MPE_WB_RELU_EN
    return v[31] ? 32'd0 : v;
`else
    return v;
`endif
  endfunction

  function automatic logic [511:0] mk_line(input int first, input int n);
    logic [511:0] r = '0;
    for (int l = 0; l < 16; l++)
      if (l < n) r[32*l +: 32] = 32'(first + l);
    return r;
  endfunction

  task automatic start(input logic [15:0] base, input logic [15:0] num);
    cfg_start = 1'b1;
    cfg_base_addr = base;
    cfg_num_res = num;
    tick;
    cfg_start = 1'b0;
  endtask

  task automatic wait_done(input int maxc, input bit rnd);
    int n = 0;
    while (!done && n < maxc) begin
      if (rnd) wb_ready = 1'($urandom_range(0, 1));
      tick;
      n++;
    end
    chk("done_seen", done, 1'b1);
    tick;
    wb_ready = 1'b1;
  endtask

  initial begin
    int dc0;
    int nl;
    logic [511:0] el;
    rst = 1'b1;
    cfg_start = 1'b0;
    cfg_base_addr = '0;
    cfg_num_res = '0;
    pe_result = '0;
    pe_vld = 1'b0;
    wb_ready = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    chk("rst_valid", wb_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_data", wb_data, '0);
    chk("rst_addr", wb_addr, 16'h0);

    // 1: two full lines, back to back, always ready
    start(16'h0010, 16'd32);
    chk("t1_busy", busy, 1'b1);
    for (int v = 1; v <= 32; v++) begin
      pe_vld = 1'b1;
      pe_result = 32'(v);
      tick;
      if (v == 16) begin
        chk("t1_l0_valid", wb_valid, 1'b1);
        chk("t1_l0_addr", wb_addr, 16'h0010);
        chk("t1_l0_data", wb_data, mk_line(1, 16));
      end
    end
    pe_vld = 1'b0;
    chk("t1_l1_valid", wb_valid, 1'b1);
    chk("t1_l1_addr", wb_addr, 16'h0011);
    chk("t1_l1_data", wb_data, mk_line(17, 16));
    tick;
    chk("t1_drain_done", done, 1'b0);
    chk("t1_drain_valid", wb_valid, 1'b0);
    tick;
    chk("t1_done", done, 1'b1);
    tick;
    chk("t1_done_drop", done, 1'b0);
    chk("t1_idle", busy, 1'b0);
    chk("t1_nlines", 512'(q_data.size()), 512'd2);
    chk("t1_q0", q_data[0], mk_line(1, 16));
    chk("t1_q1", q_data[1], mk_line(17, 16));
    chk("t1_q1_addr", q_addr[1], 16'h0011);
    chk("t1_ndone", 512'(done_cnt), 512'd1);

    // 2: partial last line is zero filled
    q_data.delete();
    q_addr.delete();
    dc0 = done_cnt;
    start(16'h0020, 16'd20);
    for (int v = 1; v <= 20; v++) begin
      pe_vld = 1'b1;
      pe_result = 32'(v);
      tick;
    end
    pe_vld = 1'b0;
    wait_done(20, 1'b0);
    tick;
    tick;
    chk("t2_ndone", 512'(done_cnt - dc0), 512'd1);
    chk("t2_nlines", 512'(q_data.size()), 512'd2);
    chk("t2_l0", q_data[0], mk_line(1, 16));
    chk("t2_l1", q_data[1], mk_line(17, 4));
    chk("t2_l1_addr", q_addr[1], 16'h0021);

    // 3: stalled sink, fifth line lost
    q_data.delete();
    q_addr.delete();
    dc0 = done_cnt;
    wb_ready = 1'b0;
    start(16'h0040, 16'd80);
    for (int v = 1; v <= 80; v++) begin
      pe_vld = 1'b1;
      pe_result = 32'(v);
      tick;
    end
    pe_vld = 1'b0;
    tick;
    tick;
    chk("t3_ovf", overflow, 1'b1);
    chk("t3_valid", wb_valid, 1'b1);
    chk("t3_head_addr", wb_addr, 16'h0040);
    chk("t3_head_data", wb_data, mk_line(1, 16));
    chk("t3_busy", busy, 1'b1);
    for (int i = 0; i < 6; i++) begin
      wb_ready = 1'(i % 2);
      tick;
    end
    wb_ready = 1'b1;
    wait_done(30, 1'b0);
    chk("t3_nlines", 512'(q_data.size()), 512'd4);
    for (int j = 0; j < q_data.size() && j < 4; j++) begin
      chk("t3_line", q_data[j], mk_line(16 * j + 1, 16));
      chk("t3_addr", q_addr[j], 16'(16'h0040 + j));
    end
    chk("t3_ndone", 512'(done_cnt - dc0), 512'd1);
    chk("t3_ovf_sticky", overflow, 1'b1);
    chk("t3_stable", 512'(stall_err), 512'd0);

    // 4: empty job, stray pe_vld while idle
    pe_vld = 1'b1;
    pe_result = 32'h99;
    tick;
    pe_vld = 1'b0;
    chk("t4_idle_valid", wb_valid, 1'b0);
    q_data.delete();
    q_addr.delete();
    dc0 = done_cnt;
    start(16'h0077, 16'd0);
    chk("t4_done", done, 1'b1);
    chk("t4_ovf_clr", overflow, 1'b0);
    chk("t4_novalid", wb_valid, 1'b0);
    tick;
    chk("t4_done_drop", done, 1'b0);
    chk("t4_idle", busy, 1'b0);
    chk("t4_ndone", 512'(done_cnt - dc0), 512'd1);
    chk("t4_nlines", 512'(q_data.size()), 512'd0);

    // 6: sign handling of negative results
    start(16'h0100, 16'd2);
    pe_vld = 1'b1;
    pe_result = 32'hFFFF_FFFB;
    tick;
    pe_result = 32'd7;
    tick;
    pe_vld = 1'b0;
    wait_done(20, 1'b0);
    el = '0;
    el[31:0] = relu(32'hFFFF_FFFB);
    el[63:32] = 32'd7;
    chk("t6_nlines", 512'(q_data.size()), 512'd1);
    chk("t6_line", q_data[0], el);
    chk("t6_addr", q_addr[0], 16'h0100);

    // 5: random gaps and backpressure, address wrap
    q_data.delete();
    q_addr.delete();
    for (int i = 0; i < 1000; i++) vals[i] = $urandom;
    start(16'hFFFE, 16'd1000);
    for (int i = 0; i < 1000; i++) begin
      while ($urandom_range(0, 3) != 0) begin
        pe_vld = 1'b0;
        wb_ready = 1'($urandom_range(0, 1));
        tick;
      end
      pe_vld = 1'b1;
      pe_result = vals[i];
      wb_ready = 1'($urandom_range(0, 1));
      tick;
    end
    pe_vld = 1'b0;
    wait_done(600, 1'b1);
    chk("t5_ovf", overflow, 1'b0);
    chk("t5_nlines", 512'(q_data.size()), 512'd63);
    nl = q_data.size();
    for (int j = 0; j < nl && j < 63; j++) begin
      el = '0;
      for (int l = 0; l < 16; l++)
        if (16 * j + l < 1000) el[32*l +: 32] = relu(vals[16 * j + l]);
      chk("t5_line", q_data[j], el);
      chk("t5_addr", q_addr[j], 16'(32'hFFFE + j));
    end
    chk("t5_stable", 512'(stall_err), 512'd0);

    // reset in the middle of a job
    dc0 = done_cnt;
    wb_ready = 1'b0;
    start(16'h0005, 16'd50);
    for (int v = 1; v <= 20; v++) begin
      pe_vld = 1'b1;
      pe_result = 32'(v);
      tick;
    end
    pe_vld = 1'b0;
    chk("rj_pre_valid", wb_valid, 1'b1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rj_valid", wb_valid, 1'b0);
    chk("rj_busy", busy, 1'b0);
    chk("rj_done", done, 1'b0);
    chk("rj_ovf", overflow, 1'b0);
    chk("rj_data", wb_data, '0);
    chk("rj_addr", wb_addr, 16'h0);
    for (int i = 0; i < 5; i++) tick;
    chk("rj_nodone", 512'(done_cnt - dc0), 512'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
